// File: rtl/loop_step_gen.sv
// Nested-loop step issuer: walks an odometer index space (level 0 fastest) over latched bounds.
// One step per valid/ready handshake, first step one cycle after start; optional abort under LSG_ABORT_EN.
module loop_step_gen #(
    parameter int BIT_WIDTH = 2,
    parameter int LEVELS    = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEVELS*BIT_WIDTH-1:0] max_count,
`ifdef LSG_ABORT_EN
    input  logic                        abort,
`endif
    output logic                        step_valid,
    input  logic                        step_ready,
    output logic [LEVELS*BIT_WIDTH-1:0] step_idx,
    output logic [LEVELS-1:0]           step_wrap,
    output logic                        busy,
    output logic                        done
);
    localparam int W = LEVELS * BIT_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W-1:0]        r_idx;
    logic [W-1:0]        r_bound;
    logic [W-1:0]        w_idx_nxt;
    logic [LEVELS-1:0]   w_at_bound;
    logic [LEVELS-1:0]   w_wrap;
    logic                w_abort;
    logic                w_accept;

`ifdef LSG_ABORT_EN
    assign w_abort = abort && (r_state == S_RUN);
`else
    assign w_abort = 1'b0;
`endif

    // An aborted cycle never counts as a handshake, even with ready high.
    assign w_accept = (r_state == S_RUN) && step_ready && !w_abort;

    always_comb begin
        logic c;
        w_at_bound = '0;
        w_wrap     = '0;
        c          = 1'b1;
        for (int k = 0; k < LEVELS; k++) begin
            w_at_bound[k] = (r_idx[k*BIT_WIDTH +: BIT_WIDTH] == r_bound[k*BIT_WIDTH +: BIT_WIDTH]);
            c             = c & w_at_bound[k];
            w_wrap[k]     = c;
        end
    end

    // Ripple-carry odometer; the final step rolls every level back to zero.
    always_comb begin
        logic c;
        w_idx_nxt = r_idx;
        c         = 1'b1;
        for (int k = 0; k < LEVELS; k++) begin
            if (c) begin
                if (w_at_bound[k]) begin
                    w_idx_nxt[k*BIT_WIDTH +: BIT_WIDTH] = '0;
                end else begin
                    w_idx_nxt[k*BIT_WIDTH +: BIT_WIDTH] = r_idx[k*BIT_WIDTH +: BIT_WIDTH] + 1'b1;
                    c = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_abort) begin
                    w_next = S_IDLE;
                end else if (w_accept && w_wrap[LEVELS-1]) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_bound <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_idx   <= '0;
            r_bound <= max_count;
        end else if (w_abort) begin
            r_idx   <= '0;
        end else if (w_accept) begin
            r_idx   <= w_idx_nxt;
        end
    end

    assign step_valid = (r_state == S_RUN);
    assign busy       = (r_state == S_RUN) || (r_state == S_DONE);
    assign done       = (r_state == S_DONE);
    assign step_idx   = r_idx;
    assign step_wrap  = (r_state == S_RUN) ? w_wrap : '0;

endmodule
